// File: rtl/systolic_mm_ctrl_array.sv
//==============================================================================
// Module   : systolic_mm_ctrl_array
// Purpose  : Output-stationary systolic C = A x W engine with stream input,
//            run-length controller and row-serial result drain.
// Revision : 1.0
//==============================================================================
`default_nettype none

module systolic_mm_ctrl_array #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int KLEN_W = 16,
    parameter int SIGNED = 1,
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    start_i,
    input  logic [KLEN_W-1:0]       k_len_i,
    output logic                    busy_o,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [ROWS*DATA_W-1:0]  in_a_i,
    input  logic [COLS*DATA_W-1:0]  in_w_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [COLS*ACC_W-1:0]   out_data_o,
    output logic [ROW_W-1:0]        out_row_o,
    output logic                    out_last_o,
    output logic                    ovf_o
);

    localparam int FLUSH_W = $clog2(ROWS + COLS);
    localparam logic [FLUSH_W-1:0] c_FLUSH_LAST = FLUSH_W'(ROWS + COLS - 2);
    localparam logic [ROW_W-1:0]   c_LAST_ROW   = ROW_W'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_FLUSH = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [KLEN_W-1:0]   klen_q, klen_d;
    logic [KLEN_W-1:0]   beat_q, beat_d;
    logic [FLUSH_W-1:0]  flush_q, flush_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic                ovf_q, ovf_d;

    logic                    w_fire;
    logic                    w_start;
    logic [ROWS*DATA_W-1:0]  w_inj_a;
    logic [COLS*DATA_W-1:0]  w_inj_w;
    logic                    w_inj_v;
    logic [ROWS*COLS-1:0]    w_pe_ovf;

    logic [DATA_W-1:0]  w_a_sk  [ROWS];
    logic [DATA_W:0]    w_wv_sk [COLS];
    logic [DATA_W-1:0]  w_pe_a   [ROWS][COLS];
    logic [DATA_W-1:0]  w_pe_w   [ROWS][COLS];
    logic               w_pe_v   [ROWS][COLS];
    logic [ACC_W-1:0]   w_pe_acc [ROWS][COLS];

    assign w_fire  = (state_q == S_FEED) && in_valid_i;
    assign w_start = (state_q == S_IDLE) && start_i;

    // Non-accepted cycles inject zeros with valid low, i.e. a bubble.
    assign w_inj_a = w_fire ? in_a_i : '0;
    assign w_inj_w = w_fire ? in_w_i : '0;
    assign w_inj_v = w_fire;

    //--------------------------------------------------------------------------
    // Input skew: A lane i delayed i cycles, W lane j (with valid) j cycles
    //--------------------------------------------------------------------------
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_a_skew
        if (gi == 0) begin : g_direct
            assign w_a_sk[gi] = w_inj_a[DATA_W-1:0];
        end else begin : g_delay
            logic [DATA_W-1:0] sr_q [gi];
            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    for (int k = 0; k < gi; k++) sr_q[k] <= '0;
                end else begin
                    sr_q[0] <= w_inj_a[gi*DATA_W +: DATA_W];
                    for (int k = 1; k < gi; k++) sr_q[k] <= sr_q[k-1];
                end
            end
            assign w_a_sk[gi] = sr_q[gi-1];
        end
    end

    for (genvar gj = 0; gj < COLS; gj++) begin : g_w_skew
        if (gj == 0) begin : g_direct
            assign w_wv_sk[gj] = {w_inj_v, w_inj_w[DATA_W-1:0]};
        end else begin : g_delay
            logic [DATA_W:0] sr_q [gj];
            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    for (int k = 0; k < gj; k++) sr_q[k] <= '0;
                end else begin
                    sr_q[0] <= {w_inj_v, w_inj_w[gj*DATA_W +: DATA_W]};
                    for (int k = 1; k < gj; k++) sr_q[k] <= sr_q[k-1];
                end
            end
            assign w_wv_sk[gj] = sr_q[gj-1];
        end
    end

    //--------------------------------------------------------------------------
    // PE array: a flows right, w and valid flow down, accumulator stays put
    //--------------------------------------------------------------------------
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        for (genvar gj = 0; gj < COLS; gj++) begin : g_pe
            logic [DATA_W-1:0] a_in, w_in, a_q, w_q;
            logic              v_in, v_q;
            logic [ACC_W-1:0]  acc_q, prod_ext, sum;
            logic              add_ovf;

            if (gj == 0) begin : g_a_edge
                assign a_in = w_a_sk[gi];
            end else begin : g_a_chain
                assign a_in = w_pe_a[gi][gj-1];
            end

            if (gi == 0) begin : g_w_edge
                assign {v_in, w_in} = w_wv_sk[gj];
            end else begin : g_w_chain
                assign w_in = w_pe_w[gi-1][gj];
                assign v_in = w_pe_v[gi-1][gj];
            end

            if (SIGNED != 0) begin : g_signed
                logic signed [2*DATA_W-1:0] prod;
                assign prod = $signed({{DATA_W{a_q[DATA_W-1]}}, a_q})
                            * $signed({{DATA_W{w_q[DATA_W-1]}}, w_q});
                assign prod_ext = ACC_W'(prod);
                assign sum      = acc_q + prod_ext;
                assign add_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1])
                               && (sum[ACC_W-1] != acc_q[ACC_W-1]);
            end else begin : g_unsigned
                logic [2*DATA_W-1:0] prod;
                logic [ACC_W:0]      sum_x;
                assign prod     = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, w_q};
                assign prod_ext = ACC_W'(prod);
                assign sum_x    = {1'b0, acc_q} + {1'b0, prod_ext};
                assign sum      = sum_x[ACC_W-1:0];
                assign add_ovf  = sum_x[ACC_W];
            end

            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    a_q   <= '0;
                    w_q   <= '0;
                    v_q   <= 1'b0;
                    acc_q <= '0;
                end else begin
                    a_q <= a_in;
                    w_q <= w_in;
                    v_q <= v_in;
                    if (w_start) begin
                        acc_q <= '0;
                    end else if (v_q) begin
                        acc_q <= sum;
                    end
                end
            end

            assign w_pe_a[gi][gj]          = a_q;
            assign w_pe_w[gi][gj]          = w_q;
            assign w_pe_v[gi][gj]          = v_q;
            assign w_pe_acc[gi][gj]        = acc_q;
            assign w_pe_ovf[gi*COLS + gj]  = v_q && add_ovf;
        end
    end

    //--------------------------------------------------------------------------
    // Run controller
    //--------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            klen_q  <= '0;
            beat_q  <= '0;
            flush_q <= '0;
            row_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            klen_q  <= klen_d;
            beat_q  <= beat_d;
            flush_q <= flush_d;
            row_q   <= row_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        klen_d  = klen_q;
        beat_d  = beat_q;
        flush_d = flush_q;
        row_d   = row_q;
        ovf_d   = ovf_q | (|w_pe_ovf);
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    klen_d  = k_len_i;
                    beat_d  = '0;
                    row_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (k_len_i == '0) ? S_DRAIN : S_FEED;
                end
            end
            S_FEED: begin
                if (in_valid_i) begin
                    beat_d = beat_q + KLEN_W'(1);
                    if (beat_q == klen_q - KLEN_W'(1)) begin
                        state_d = S_FLUSH;
                        flush_d = '0;
                    end
                end
            end
            S_FLUSH: begin
                // Lets the final beat reach the bottom-right PE and accumulate.
                flush_d = flush_q + FLUSH_W'(1);
                if (flush_q == c_FLUSH_LAST) begin
                    state_d = S_DRAIN;
                    row_d   = '0;
                end
            end
            S_DRAIN: begin
                if (out_ready_i) begin
                    if (row_q == c_LAST_ROW) begin
                        state_d = S_IDLE;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o      = (state_q != S_IDLE);
    assign in_ready_o  = (state_q == S_FEED);
    assign out_valid_o = (state_q == S_DRAIN);
    assign out_row_o   = row_q;
    assign out_last_o  = out_valid_o && (row_q == c_LAST_ROW);
    assign ovf_o       = ovf_q;

    for (genvar gj = 0; gj < COLS; gj++) begin : g_out
        assign out_data_o[gj*ACC_W +: ACC_W] = out_valid_o ? w_pe_acc[row_q][gj] : '0;
    end

endmodule

`default_nettype wire

// File: tb/tb_systolic_mm_ctrl_array.sv
//==============================================================================
// Module   : tb_systolic_mm_ctrl_array
// Purpose  : Directed self-checking bench for systolic_mm_ctrl_array (4x4, 8/16-bit signed).
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_systolic_mm_ctrl_array;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;
    localparam int KLEN_W = 16;

    logic                    clk = 1'b0;
    logic                    rstn;
    logic                    start;
    logic [KLEN_W-1:0]       k_len;
    logic                    busy;
    logic                    in_valid;
    logic                    in_ready;
    logic [ROWS*DATA_W-1:0]  in_a;
    logic [COLS*DATA_W-1:0]  in_w;
    logic                    out_valid;
    logic                    out_ready;
    logic [COLS*ACC_W-1:0]   out_data;
    logic [1:0]              out_row;
    logic                    out_last;
    logic                    ovf;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] beat_a [8];
    logic [31:0] beat_w [8];
    logic [15:0] exp_c  [4][4];

    always #5 clk = ~clk;

    systolic_mm_ctrl_array #(
        .ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W),
        .ACC_W(ACC_W), .KLEN_W(KLEN_W), .SIGNED(1)
    ) dut (
        .clk_i(clk), .rstn_i(rstn), .start_i(start), .k_len_i(k_len),
        .busy_o(busy), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_a_i(in_a), .in_w_i(in_w), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_data_o(out_data), .out_row_o(out_row),
        .out_last_o(out_last), .ovf_o(ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_row(input int r);
        logic [63:0] v;
        for (int j = 0; j < 4; j++) v[j*16 +: 16] = exp_c[r][j];
        return v;
    endfunction

    task automatic set_all(input logic [7:0] a, input logic [7:0] w, input logic [15:0] c);
        for (int k = 0; k < 8; k++) begin
            beat_a[k] = {4{a}};
            beat_w[k] = {4{w}};
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) exp_c[i][j] = c;
    endtask

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic do_start(input logic [15:0] k);
        start = 1'b1;
        k_len = k;
        @(negedge clk);
        start = 1'b0;
        k_len = '0;
        chk("busy_after_start", busy, 1);
        chk("in_ready_first", in_ready, (k != 0));
        chk("ovf_cleared_by_start", ovf, 0);
    endtask

    task automatic feed(input int k, input bit gaps);
        for (int b = 0; b < k; b++) begin
            if (gaps && b > 0) begin
                in_valid = 1'b0;
                in_a     = '1;
                in_w     = '1;
                @(negedge clk);
            end
            chk("in_ready_feed", in_ready, 1);
            in_valid = 1'b1;
            in_a     = beat_a[b];
            in_w     = beat_w[b];
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_a     = '0;
        in_w     = '0;
        chk("in_ready_after_feed", in_ready, 0);
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 40 && !out_valid; c++) @(negedge clk);
        chk("drain_reached", out_valid, 1);
    endtask

    task automatic drain(input logic [3:0] pat, input bit exp_ovf, input bit start_last);
        int er  = 0;
        int idx = 0;
        int cyc = 0;
        while (er < 4 && cyc < 40) begin
            chk("out_valid", out_valid, 1);
            chk("out_row", out_row, er);
            chk("out_last", out_last, (er == 3));
            chk("out_data", out_data, exp_row(er));
            chk("ovf_drain", ovf, exp_ovf);
            out_ready = pat[idx % 4];
            start     = start_last && out_ready && (er == 3);
            k_len     = 16'd5;
            idx++;
            @(negedge clk);
            cyc++;
            if (out_ready) er++;
        end
        out_ready = 1'b0;
        start     = 1'b0;
        k_len     = '0;
        chk("rows_drained", er, 4);
        chk("out_valid_end", out_valid, 0);
        chk("busy_end", busy, 0);
        chk("out_last_end", out_last, 0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_row", out_row, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_ovf", ovf, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; start = 1'b0; k_len = '0; in_valid = 1'b0;
        in_a = '0; in_w = '0; out_ready = 1'b0;
        #1;
        chk_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Identity W, A[i][k] = 4i+k+1: C equals A.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) beat_a[k][i*8 +: 8] = 8'(i*4 + k + 1);
            for (int j = 0; j < 4; j++) beat_w[k][j*8 +: 8] = (j == k) ? 8'd1 : 8'd0;
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) exp_c[i][j] = 16'(i*4 + j + 1);
        do_start(16'd4);
        feed(4, 1'b0);
        wait_drain();
        drain(4'b1111, 1'b0, 1'b0);

        // All ones, K=3 with bubbles between beats.
        set_all(8'd1, 8'd1, 16'd3);
        do_start(16'd3);
        feed(3, 1'b1);
        wait_drain();
        drain(4'b1111, 1'b0, 1'b0);

        // K=8, a=2 w=3, drain stalls with ready pattern 1,0,0,1.
        set_all(8'd2, 8'd3, 16'd48);
        do_start(16'd8);
        feed(8, 1'b0);
        wait_drain();
        drain(4'b1001, 1'b0, 1'b0);

        // K=0: straight to drain with zero rows; start on final handshake ignored.
        set_all(8'd0, 8'd0, 16'd0);
        do_start(16'd0);
        chk("k0_no_ready", in_ready, 0);
        chk("k0_in_drain", out_valid, 1);
        drain(4'b1111, 1'b0, 1'b1);
        @(negedge clk);
        chk("start_on_last_ignored", busy, 0);

        // Signed overflow: (-128)*(-128) three times wraps to 0xC000.
        set_all(8'h80, 8'h80, 16'hC000);
        do_start(16'd3);
        feed(3, 1'b0);
        wait_drain();
        drain(4'b1111, 1'b1, 1'b0);
        chk("ovf_held_idle", ovf, 1);

        // Next start clears ovf; abort with reset after two beats.
        set_all(8'd5, 8'd5, 16'd0);
        do_start(16'd4);
        for (int b = 0; b < 2; b++) begin
            in_valid = 1'b1; in_a = beat_a[b]; in_w = beat_w[b];
            @(negedge clk);
        end
        in_valid = 1'b0; in_a = '0; in_w = '0;
        chk("busy_before_abort", busy, 1);
        rstn = 1'b0;
        #1;
        chk_reset_outputs();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Fresh K=1 all-ones run after the abort.
        set_all(8'd1, 8'd1, 16'd1);
        do_start(16'd1);
        feed(1, 1'b0);
        wait_drain();
        drain(4'b1111, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/systolic_mm_ctrl_array.md
Name: systolic_mm_ctrl_array

Overview:
- Parametrised output-stationary systolic matrix-multiply engine computing C[ROWS][COLS] = A[ROWS][K] x W[K][COLS].
- Extends the fixed 4x4/8-bit PE array with:
  - generic operand and accumulator widths, and a signed/unsigned mode;
  - internal input skew, with a valid bit travelling alongside the data;
  - a run-length controller FSM;
  - a valid/ready input stream and row-serial result drain.
- Sits between the operand buffers (A columns, W rows) and the result writeback.

Parameters:
ROWS, 4, array rows (A lanes), >=1
COLS, 4, array columns (W lanes), >=1
DATA_W, 8, operand width
ACC_W, 24, accumulator width, >= 2*DATA_W
KLEN_W, 16, width of run-length input
SIGNED, 1, 1 = two's-complement operands/accumulators, 0 = unsigned

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
start  in  1  run request pulse; sampled only in IDLE
k_len  in  KLEN_W  run depth K, sampled with start
busy  out  1  high in any state other than IDLE
in_valid  in  1  operand beat valid
in_ready  out  1  operand beat accepted when in_valid&in_ready
in_a  in  ROWS*DATA_W  column k of A; lane i = [i*DATA_W +: DATA_W]
in_w  in  COLS*DATA_W  row k of W; lane j = [j*DATA_W +: DATA_W]
out_valid  out  1  result row valid
out_ready  in  1  result sink ready
out_data  out  COLS*ACC_W  row out_row of C; lane j = [j*ACC_W +: ACC_W]
out_row  out  $clog2(ROWS) (min 1)  row index of out_data
out_last  out  1  high with row ROWS-1
ovf  out  1  sticky accumulator-overflow flag for current run

Behaviour:
- Reset (async, rstn=0):
  - FSM returns to IDLE; all accumulators, skew/PE registers and valid bits are cleared.
  - Outputs: busy=0, in_ready=0, out_valid=0, out_data=0, out_row=0, out_last=0, ovf=0.
  - Reset mid-run aborts the run; no partial results are emitted.
- FSM states: IDLE, FEED, FLUSH, DRAIN.
- IDLE:
  - On start, latch k_len, clear all accumulators and ovf.
  - k_len!=0 -> FEED; k_len==0 -> DRAIN, which emits all-zero rows.
  - start is ignored in every state other than IDLE.
- FEED:
  - in_ready=1; in_ready is 0 in every other state. First cycle of in_ready=1 is the cycle after start.
  - Each handshake injects one beat and increments the beat counter.
  - The handshake of beat k_len-1 moves the FSM to FLUSH.
  - in_valid=0 injects a bubble (valid=0) that propagates through the array without accumulating.
- Skew and PE datapath:
  - Lane i of A is delayed i cycles; lane j of W is delayed j cycles.
  - Each PE registers a, w and valid and forwards them right (a) and down (w, valid).
  - Each PE accumulates a*w only when its valid is set.
  - A beat accepted in cycle t reaches PE(i,j) at cycle t+i+j+1.
- FLUSH: a counter runs ROWS+COLS-1 cycles so the last beat reaches PE(ROWS-1,COLS-1), then the FSM moves to DRAIN.
- DRAIN:
  - out_valid=1, out_data holds row out_row, starting at row 0.
  - On out_valid&out_ready, out_row increments.
  - out_last=1 while out_row==ROWS-1; that handshake returns the FSM to IDLE with out_valid=0.
  - While out_ready=0, out_data, out_row and out_last stay stable.
- Arithmetic:
  - Product is 2*DATA_W bits, signed or unsigned per SIGNED, extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W.
  - ovf is set if any PE's add overflows: signed overflow when SIGNED=1, carry-out when SIGNED=0.
  - ovf holds until the next accepted start or reset; it is valid during DRAIN.
- Simultaneous events:
  - start arriving in the same cycle as the final DRAIN handshake is ignored; the FSM is not yet in IDLE.
  - in_valid outside FEED has no effect.

Test Plan:
- ROWS=COLS=4, K=4, W=identity, A[i][k]=i*4+k+1 -> C=A; 4 drain beats, out_last on row 3, ovf=0, busy falls the cycle after the last handshake.
- K=3, in_valid deasserted every other cycle -> same C as a gap-free run: all-ones A and W give every C element = 3.
- K=8, out_ready pattern 1,0,0,1 during drain -> out_data/out_row held across stalls, rows 0..3 each emitted exactly once, every element = 8*product.
- start with k_len=0 -> in_ready never asserted, 4 rows of zeros, out_last on row 3.
- SIGNED=1, DATA_W=8, ACC_W=16, K=3, all operands -128 (each product 16384) -> cumulative sum 49152 exceeds 32767; accumulators wrap (every element = 0xC000 = -16384) and ovf=1. Next start clears ovf.
- rstn asserted mid-FEED after 2 beats -> all outputs 0 immediately; a fresh K=1 run with all-ones operands yields all-1 C, uncontaminated by the aborted run.
